// File: rtl/gpu_pkg.sv
// Shared opcodes, sequencer state encoding and instruction field helpers for gpu_core_param.
package gpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_CID   = 4'd0;  // NOP when IR[11:0]==0, CID otherwise
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_CMPGE = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;
  localparam logic [3:0] OP_LD    = 4'd11;
  localparam logic [3:0] OP_LI    = 4'd12;
  localparam logic [3:0] OP_ST    = 4'd13;
  localparam logic [3:0] OP_BNZ   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEM_WAIT, S_WB
  } state_t;

  function automatic logic [3:0] f_op(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [3:0] f_ra(input logic [15:0] ir);
    return ir[11:8];
  endfunction

  function automatic logic [3:0] f_rb(input logic [15:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] ir);
    return ir[3:0];
  endfunction

endpackage

// File: rtl/gpu_alu.sv
// Combinational DW-wide ALU for opcodes ADD..XOR; results truncated to DW, divide by zero gives all ones.
module gpu_alu
  import gpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_MUL:   y = a * b;
      OP_DIV:   y = (b == '0) ? '1 : a / b;
      OP_CMPGE: y[0] = (a >= b);
      OP_SHR:   y = a >> b[3:0];
      OP_SHL:   y = a << b[3:0];
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/gpu_core_param.sv
// SIMT-lane core: loads a program over valid/ready, runs FETCH..WB per instruction, flags completion.
// Perf counters are built only when GPU_CORE_PERF_EN is defined.
module gpu_core_param
  import gpu_pkg::*;
#(
  parameter int         DW         = 8,
  parameter int         AW         = 12,
  parameter int         IMEM_DEPTH = 16,
  parameter logic [3:0] CORE_ID    = 4'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          val_ins,
  input  logic [15:0]   instruction,
  output logic          rtr,
  output logic          ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] addr_shared_memory,
  output logic [DW-1:0] mem_dat_st,
  input  logic [DW-1:0] mem_dat,
  input  logic          val_data,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_instrs
);

  localparam int             PCW  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [PCW-1:0] LAST = PCW'(IMEM_DEPTH - 1);

  state_t         state, state_nx;
  logic [15:0]    imem [IMEM_DEPTH];
  logic [DW-1:0]  rf [16];
  logic [15:0]    ir;
  logic [PCW-1:0] pc, ld_idx;
  logic [DW-1:0]  a_q, b_q, d_q, res_q, alu_y, ex_res;
  logic           done_q;
  logic [3:0]     op;
  logic           is_mem, taken, finish, wr_en, load_done;

  assign op        = f_op(ir);
  assign ready     = done_q;
  assign is_mem    = (op == OP_LD) || (op == OP_ST);
  assign taken     = (op == OP_BNZ) && (a_q != '0);
  assign finish    = (op == OP_HALT) || ((pc == LAST) && !taken);
  assign load_done = val_ins && (ld_idx == LAST);
  assign wr_en     = ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_LI) || (op == OP_LD) ||
                     ((op == OP_CID) && (ir[11:0] != '0));

  gpu_alu #(.DW(DW)) u_alu (.op(op), .a(a_q), .b(b_q), .y(alu_y));

  always_comb begin
    ex_res = alu_y;
    if (op == OP_LI) begin
      ex_res      = '0;
      ex_res[7:0] = ir[11:4];
    end else if (op == OP_CID) begin
      ex_res      = '0;
      ex_res[3:0] = CORE_ID;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:     if (load_done) state_nx = S_FETCH;
      S_FETCH:    state_nx = S_DECODE;
      S_DECODE:   state_nx = S_EXEC;
      S_EXEC:     state_nx = S_MEM;
      S_MEM:      state_nx = is_mem ? S_MEM_WAIT : S_WB;
      S_MEM_WAIT: if (val_data) state_nx = S_WB;
      S_WB:       state_nx = finish ? S_LOAD : S_FETCH;
      default:    state_nx = S_LOAD;
    endcase
  end

  // FSM: outputs; the request stays up for exactly the MEM_WAIT residency
  always_comb begin
    rtr     = (state == S_LOAD);
    mem_req = (state == S_MEM_WAIT);
  end

  // Program memory has no reset; its contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    if (rtr && val_ins) imem[ld_idx] <= instruction;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                 <= '0;
      ld_idx             <= '0;
      ir                 <= '0;
      a_q                <= '0;
      b_q                <= '0;
      d_q                <= '0;
      res_q              <= '0;
      done_q             <= 1'b0;
      mem_we             <= 1'b0;
      addr_shared_memory <= '0;
      mem_dat_st         <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_LOAD: if (val_ins) begin
          ld_idx <= load_done ? '0 : ld_idx + 1'b1;
          if (ld_idx == '0) done_q <= 1'b0;
          if (load_done)    pc     <= '0;
        end
        S_FETCH:  ir <= imem[pc];
        S_DECODE: begin
          a_q <= rf[f_ra(ir)];
          b_q <= rf[f_rb(ir)];
          d_q <= rf[f_rd(ir)];
        end
        S_EXEC:   res_q <= ex_res;
        S_MEM: if (is_mem) begin
          mem_we             <= (op == OP_ST);
          addr_shared_memory <= AW'({b_q, a_q});
          if (op == OP_ST) mem_dat_st <= d_q;
        end
        S_MEM_WAIT: if (val_data && (op == OP_LD)) res_q <= mem_dat;
        S_WB: begin
          if (wr_en) rf[f_rd(ir)] <= res_q;
          if (finish) begin
            done_q <= 1'b1;
            ld_idx <= '0;
          end else begin
            pc <= taken ? ir[PCW-1:0] : pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GPU_CORE_PERF_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else if (state == S_LOAD) begin
      if (load_done) begin
        cyc_q <= '0;
        ins_q <= '0;
      end
    end else begin
      if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if ((state == S_WB) && (ins_q != '1)) ins_q <= ins_q + 1'b1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_instrs = ins_q;
`else
  assign perf_cycles = '0;
  assign perf_instrs = '0;
`endif

endmodule

// File: tb/tb_gpu_core_param.sv
// Bench for gpu_core_param: an ISA-level interpreter expands each program into a per-cycle
// expectation timeline (5 cycles per instruction plus memory stall) that a negedge checker compares.
module tb_gpu_core_param;

  localparam int         DW    = 8;
  localparam int         AW    = 12;
  localparam int         DEPTH = 16;
  localparam logic [3:0] CID   = 4'hB;

  logic          clk = 1'b0, reset = 1'b1, val_ins = 1'b0, val_data = 1'b0;
  logic [15:0]   instruction = '0;
  logic [DW-1:0] mem_dat = '0;
  logic          rtr, ready, mem_req, mem_we;
  logic [AW-1:0] addr_shared_memory;
  logic [DW-1:0] mem_dat_st;
  logic [31:0]   perf_cycles, perf_instrs;

  gpu_core_param #(.DW(DW), .AW(AW), .IMEM_DEPTH(DEPTH), .CORE_ID(CID)) dut (
    .clk(clk), .reset(reset), .val_ins(val_ins), .instruction(instruction), .rtr(rtr),
    .ready(ready), .mem_req(mem_req), .mem_we(mem_we), .addr_shared_memory(addr_shared_memory),
    .mem_dat_st(mem_dat_st), .mem_dat(mem_dat), .val_data(val_data),
    .perf_cycles(perf_cycles), .perf_instrs(perf_instrs)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-cycle expectation produced by the interpreter
  typedef struct {
    bit            req;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    bit            fin;
    bit            vd;
    logic [DW-1:0] md;
    bit            vi;
  } ent_t;

  logic [DW-1:0] mrf [16];
  logic [DW-1:0] mmem [4096];
  ent_t          tl[$];
  ent_t          cur;
  bit            chk_on = 1'b0;
  int            exp_instrs, exp_cycles;
  int            fixed_stall = 0;
  int            run_cyc = 0;
  logic [31:0]   st_log[$];
  logic          prev_req = 1'b0;

  // Compare process: DUT outputs against the current timeline entry every cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rtr", 32'(rtr), 32'(cur.fin));
      chk("ready", 32'(ready), 32'(cur.fin));
      chk("mem_req", 32'(mem_req), 32'(cur.req));
      if (cur.req) begin
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_addr", 32'(addr_shared_memory), 32'(cur.addr));
        if (cur.we) chk("mem_dat_st", 32'(mem_dat_st), 32'(cur.dat));
      end
    end
    if (!rtr) run_cyc++;
    if (mem_req && !prev_req) st_log.push_back({11'b0, mem_we, addr_shared_memory, mem_dat_st});
    prev_req = mem_req;
  end

  function automatic ent_t idle();
    ent_t e;
    e.req = 0; e.we = 0; e.addr = '0; e.dat = '0; e.fin = 0;
    e.vd = 1'($urandom_range(0, 1)); e.md = DW'($urandom); e.vi = 1'($urandom_range(0, 1));
    return e;
  endfunction

  // ISA interpreter: runs the program on mrf/mmem and lays out the cycle timeline
  task automatic build(input logic [15:0] p[16]);
    int            pc, op, k;
    bit            done, wr, taken;
    logic [15:0]   ir;
    logic [3:0]    ra, rb, rd;
    logic [DW-1:0] a, b, d, r;
    logic [AW-1:0] ad;
    ent_t          e;
    tl.delete();
    pc = 0; done = 0; exp_instrs = 0;
    while (!done) begin
      ir = p[pc]; op = int'(ir[15:12]); ra = ir[11:8]; rb = ir[7:4]; rd = ir[3:0];
      a = mrf[ra]; b = mrf[rb]; d = mrf[rd];
      ad = AW'({b, a});
      r = '0; wr = 1; taken = 0;
      for (int i = 0; i < 4; i++) tl.push_back(idle());
      case (op)
        0:  begin r = DW'(CID); wr = (ir[11:0] != 0); end
        1:  r = a + b;
        2:  r = a - b;
        3:  r = a * b;
        4:  r = (b == 0) ? '1 : a / b;
        5:  r = (a >= b) ? DW'(1) : DW'(0);
        6:  r = a >> b[3:0];
        7:  r = a << b[3:0];
        8:  r = a & b;
        9:  r = a | b;
        10: r = a ^ b;
        11, 13: begin
          k = (fixed_stall > 0) ? fixed_stall : $urandom_range(1, 4);
          for (int j = 0; j < k; j++) begin
            e = idle();
            e.req = 1; e.we = (op == 13); e.addr = ad; e.dat = d;
            e.vd = (j == k - 1);
            if (j == k - 1) e.md = mmem[ad];
            tl.push_back(e);
          end
          if (op == 13) begin mmem[ad] = d; wr = 0; end
          else r = mmem[ad];
        end
        12: r = DW'(ir[11:4]);
        14: begin taken = (a != 0); wr = 0; end
        default: wr = 0;
      endcase
      tl.push_back(idle());
      if (wr) mrf[rd] = r;
      exp_instrs++;
      if (op == 15 || (pc == DEPTH - 1 && !taken)) done = 1;
      else pc = taken ? int'(ir[3:0]) : pc + 1;
    end
    exp_cycles = tl.size();
    e = idle(); e.fin = 1; e.vi = 0;
    tl.push_back(e);
  endtask

  task automatic load_prog(input logic [15:0] p[16], input bit rdy_before);
    for (int i = 0; i < DEPTH; i++) begin
      repeat ($urandom_range(0, 2)) begin
        val_ins = 0; instruction = 16'($urandom);
        @(posedge clk); #1;
      end
      if (i == 0) begin
        chk("ready_hold", 32'(ready), 32'(rdy_before));
        chk("rtr_load", 32'(rtr), 32'd1);
      end
      val_ins = 1; instruction = p[i];
      @(posedge clk); #1;
      if (i == 0) chk("ready_clr", 32'(ready), 32'd0);
    end
    val_ins = 0;
    chk("rtr_off", 32'(rtr), 32'd0);
  endtask

  task automatic run_prog(output int cyc);
    int c0 = run_cyc;
    while (tl.size() > 0) begin
      cur = tl.pop_front();
      val_data = cur.vd; mem_dat = cur.md; val_ins = cur.vi; instruction = 16'($urandom);
      chk_on = 1;
      @(posedge clk); #1;
    end
    chk_on = 0; val_ins = 0; val_data = 0;
    cyc = run_cyc - c0;
`ifdef GPU_CORE_PERF_EN
    chk("perf_cycles", perf_cycles, 32'(exp_cycles));
    chk("perf_instrs", perf_instrs, 32'(exp_instrs));
`else
    chk("perf_cycles", perf_cycles, 32'd0);
    chk("perf_instrs", perf_instrs, 32'd0);
`endif
  endtask

  task automatic gen(output logic [15:0] p[16]);
    int         r;
    logic [11:0] f;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom_range(0, 19);
      f = 12'($urandom);
      if (r <= 9)                            p[i] = {4'(r + 1), f};
      else if (r == 10 || r == 11 || r == 19) p[i] = {4'hC, f};
      else if (r == 12)                      p[i] = {4'hB, f};
      else if (r <= 15)                      p[i] = {4'hD, f};
      else if (r == 16)                      p[i] = (i < DEPTH - 1) ? {4'hE, f[11:4], 4'($urandom_range(i + 1, DEPTH - 1))} : 16'h0000;
      else if (r == 17)                      p[i] = {4'h0, ($urandom_range(0, 1) != 0) ? f : 12'h000};
      else                                   p[i] = ($urandom_range(0, 2) == 0) ? 16'hF000 : {4'hD, f};
    end
  endtask

  initial begin
    logic [15:0] p1[16], p2[16], p3[16], p4[16], pr[16];
    int cyc, l0, n;

    foreach (mmem[i]) mmem[i] = DW'($urandom);
    foreach (mrf[i]) mrf[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin p1[i] = 0; p2[i] = 0; p3[i] = 0; p4[i] = 0; end
    p1[0] = 16'hC051; p1[1] = 16'hC032; p1[2] = 16'h1123; p1[3] = 16'hF000;
    p2[0] = 16'hD123; p2[1] = 16'hC006; p2[2] = 16'h4165; p2[3] = 16'hD125;
    p2[4] = 16'hC207; p2[5] = 16'hC108; p2[6] = 16'h3789; p2[7] = 16'hD129;
    p2[8] = 16'hC121; p2[9] = 16'hCA54; p2[10] = 16'hD124; p2[11] = 16'hB12A;
    p2[12] = 16'hD12A; p2[13] = 16'hF000;
    p3[0] = 16'hC031; p3[1] = 16'hC012; p3[2] = 16'h2121; p3[3] = 16'hE102; p3[15] = 16'hD121;
    p4[0] = 16'hD123;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rtr", 32'(rtr), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(addr_shared_memory), 32'd0);
    chk("rst_dat", 32'(mem_dat_st), 32'd0);
    chk("rst_perf_c", perf_cycles, 32'd0);
    reset = 0;
    @(posedge clk); #1;

    // LI/LI/ADD/HALT: four plain instructions
    load_prog(p1, 0); build(p1); run_prog(cyc);
    chk("p1_cycles", 32'(cyc), 32'd20);
`ifdef GPU_CORE_PERF_EN
    chk("p1_perf_c", perf_cycles, 32'd20);
    chk("p1_perf_i", perf_instrs, 32'd4);
`endif

    // stores of ADD/DIV0/MUL results, then store/load/store with a 4-cycle wait
    fixed_stall = 4; l0 = st_log.size();
    load_prog(p2, 1); build(p2); run_prog(cyc);
    chk("p2_nreq", 32'(st_log.size() - l0), 32'd6);
    if (st_log.size() - l0 == 6) begin
      chk("st_add", st_log[l0], 32'h130508);
      chk("st_div0", st_log[l0 + 1], 32'h1305FF);
      chk("st_mul", st_log[l0 + 2], 32'h130500);
      chk("st_a5", st_log[l0 + 3], 32'h1312A5);
      chk("ld_a5", st_log[l0 + 4] >> 8, 32'h0312);
      chk("st_ld", st_log[l0 + 5], 32'h1312A5);
    end

    // countdown loop taken twice, exits at the last slot
    fixed_stall = 1; l0 = st_log.size();
    load_prog(p3, 1); build(p3); run_prog(cyc);
    chk("p3_cycles", 32'(cyc), 32'd101);
    chk("p3_exit_st", (st_log.size() > l0) ? st_log[l0] : 32'hDEAD, 32'h110000);
    fixed_stall = 0;

    // reset while a store is stalled in MEM_WAIT
    load_prog(p4, 1);
    n = 0;
    while (!mem_req && n < 20) begin val_data = 0; @(posedge clk); #1; n++; end
    chk("rst_req_seen", 32'(mem_req), 32'd1);
    repeat (2) @(posedge clk);
    #3; reset = 1; #1;
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_rtr", 32'(rtr), 32'd1);
    chk("mrst_ready", 32'(ready), 32'd0);
    chk("mrst_we", 32'(mem_we), 32'd0);
    chk("mrst_addr", 32'(addr_shared_memory), 32'd0);
    @(posedge clk); #1; reset = 0;
    foreach (mrf[i]) mrf[i] = '0;
    load_prog(p1, 0); build(p1); run_prog(cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd20);

    for (int t = 0; t < 25; t++) begin
      gen(pr);
      load_prog(pr, 1); build(pr); run_prog(cyc);
      chk("rnd_cycles", 32'(cyc), 32'(exp_cycles));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
